// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline hazard controller
//
// Sequences the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// It handles memory stalls, EX-resolved redirects, load-use hazards and fetch
// misses. It also keeps saturating stall and flush performance counters.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   id_rs1/2, _en       source registers of the ID instruction and their use flags
//   ex_rd, ex_mem_read  destination of the EX instruction, and a flag that it is a load
//   ex_redirect         EX resolved a taken branch or jump
//   mem_busy            MEM access not complete this cycle
//   if_valid            fetch data valid this cycle
//   pc_en               PC update enable
//   ifid_en/_flush      IF/ID load enable / load NOP (flush has priority)
//   idex_en/_flush      ID/EX load enable / load NOP
//   exmem_en            EX/MEM load enable
//   memwb_flush         MEM/WB load NOP
//   stall_cnt           cycles with pc_en=0 since reset (saturating)
//   flush_cnt           accepted redirects since reset (saturating)
module hazard_ctrl #(
    parameter int REG_AW           = 5,
    parameter int CNT_W            = 32,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_en,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    input  logic              if_valid,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic [3:0] BUBBLES = 4'(REDIRECT_BUBBLES);

    state_e           state_q, state_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu;
    logic             redirect_acc;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_rs1_en && (id_rs1 == ex_rd)) || (id_rs2_en && (id_rs2 == ex_rd)));

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_flush  = 1'b0;
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        redirect_acc = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_busy) begin
            // Whole front of the pipe freezes. A pending redirect stays in EX
            // and is taken on the first cycle the memory access completes.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redirect_acc = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
                state_d = FLUSH;
                bcnt_d  = BUBBLES;
            end else begin
                state_d = RUN;
                bcnt_d  = '0;
            end
        end else if (state_q == FLUSH) begin
            // ID holds a NOP while fetch catches up, so load-use is not checked here.
            ifid_flush = 1'b1;
            bcnt_d     = bcnt_q - 4'd1;
            if (bcnt_q <= 4'd1) begin
                state_d = RUN;
                bcnt_d  = '0;
            end
        end else if (lu) begin
            // One bubble suffices: the load reaches MEM next cycle and forwards.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!if_valid) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_acc && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            bcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC each cycle. It produces per-stage enables and flushes for four cases: multi-cycle memory stalls, EX-resolved redirects (taken branch or jump), load-use hazards and instruction-fetch misses. It also keeps saturating performance counters for stalls and flushes.

## Interface
Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, perf-counter width.
- REDIRECT_BUBBLES, 1, extra cycles IF/ID stays flushed after a redirect to cover fetch latency (0..15).

Ports (clock and reset first; reset is synchronous, active-high):
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_rs1  in  REG_AW  source register 1 of the instruction in ID.
- id_rs2  in  REG_AW  source register 2 of the instruction in ID.
- id_rs1_en  in  1  ID instruction reads rs1.
- id_rs2_en  in  1  ID instruction reads rs2.
- ex_rd  in  REG_AW  destination of the instruction in EX.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump; PC mux selects the target.
- mem_busy  in  1  MEM-stage access not complete this cycle.
- if_valid  in  1  fetch data valid this cycle.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (priority over ifid_en).
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads a NOP.
- exmem_en  out  1  EX/MEM load enable.
- memwb_flush  out  1  MEM/WB loads a NOP.
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset.
- flush_cnt  out  CNT_W  accepted redirects since reset.

## Operation
- State register: RUN or FLUSH, plus a 4-bit bubble counter bcnt.
- Load-use hazard (lu) = ex_mem_read && ex_rd!=0 && ((id_rs1_en && id_rs1==ex_rd) || (id_rs2_en && id_rs2==ex_rd)).
- Decision each cycle, first matching rule wins. Defaults: all enables 1, all flushes 0.
  1. mem_busy: pc_en=ifid_en=idex_en=exmem_en=0 and memwb_flush=1. State and bcnt hold. ex_redirect is ignored; EX is frozen, so it re-presents after the stall.
  2. ex_redirect: ifid_flush=1, idex_flush=1, pc_en=1. If REDIRECT_BUBBLES>0, the next state is FLUSH with bcnt=REDIRECT_BUBBLES; otherwise RUN. flush_cnt increments. A redirect arriving while in FLUSH reloads bcnt.
  3. state FLUSH: ifid_flush=1 and bcnt decrements. When bcnt==1 the next state is RUN. lu is ignored because ID holds a NOP.
  4. lu: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble, because the load advances to MEM next cycle.
  5. !if_valid: pc_en=0, ifid_flush=1.
- stall_cnt increments on every non-reset cycle with pc_en=0. Both counters saturate at all-ones.
- Register 0 never causes a load-use stall.

## Timing
- Outputs are combinational from state and current inputs; the decision takes zero cycles. State and counters are registered.
- A redirect at cycle N flushes IF/ID and ID/EX at edge N+1. IF/ID stays flushed for edges N+2 .. N+1+REDIRECT_BUBBLES.
- A load-use hazard inserts exactly one ID/EX bubble. The dependent instruction enters EX one cycle later than it would without the hazard.
- Reset values (any cycle rst=1): pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=memwb_flush=1, state=RUN, bcnt=0, stall_cnt=flush_cnt=0.
- rst asserted mid-FLUSH or mid-stall aborts the sequence. The first cycle after deassert is in RUN with default outputs, given no hazard inputs.
- Simultaneous mem_busy and ex_redirect: no flush that cycle. The flush happens on the first cycle mem_busy=0.
- Simultaneous ex_redirect and lu: the redirect wins and idex_flush=1; no extra stall is counted.

## Test plan
- Reset then idle (if_valid=1, everything else 0) for 5 cycles -> reset values during rst; afterwards all enables 1, flushes 0, stall_cnt=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_en=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- ex_redirect pulse with REDIRECT_BUBBLES=2 -> ifid_flush high 3 consecutive cycles, idex_flush high 1 cycle, flush_cnt=1. A second redirect in the 2nd cycle -> ifid_flush extends to 4 cycles total, flush_cnt=2.
- mem_busy held 3 cycles concurrent with ex_redirect -> all enables 0 and memwb_flush=1 for 3 cycles. The redirect flush happens on cycle 4; stall_cnt=3, flush_cnt=1.
- if_valid=0 for 2 cycles -> pc_en=0 and ifid_flush=1 for both; stall_cnt=2.
- rst asserted in the 1st FLUSH cycle (REDIRECT_BUBBLES=3) -> reset values; after deassert, default outputs immediately and both counters 0.
